// File: rtl/branch_compare_pipe_pkg.sv
// Shared types and the mode-to-condition select for the branch compare pipeline.
package branch_compare_pipe_pkg;
  `include "brcmp_defs.vh"

  typedef logic [MODE_W-1:0] brcmp_mode_t;

  // Reduced compare terms -> branch condition for one mode.
  function automatic logic brcmp_taken(
    input brcmp_mode_t mode,
    input logic        eq,
    input logic        zero,
    input logic        sign_a,
    input logic        lt_signed,
    input logic        ltu
  );
    logic t;
    t = 1'b0;
    case (mode)
      BRCMP_EQ:  t = eq;
      BRCMP_NE:  t = !eq;
      BRCMP_LTZ: t = sign_a;
      BRCMP_GEZ: t = !sign_a;
      BRCMP_GTZ: t = !sign_a && !zero;
      BRCMP_LEZ: t = sign_a || zero;
      BRCMP_LT:  t = lt_signed;
      BRCMP_LTU: t = ltu;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction
endpackage

// File: rtl/branch_compare_pipe_chunk.sv
// Combinational partial compare of one CHUNK-wide operand slice.
module brcmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             ltu,
  output logic             zero
);
  assign eq   = (a == b);
  assign ltu  = (a < b);
  assign zero = (a == '0);
endmodule

// File: rtl/brcmp_defs.vh
// Branch-compare mode encodings and mode width, shared by the decode stage
// and the branch compare pipeline.
`ifndef BRCMP_DEFS_VH
`define BRCMP_DEFS_VH
localparam int MODE_W = 3;
localparam logic [MODE_W-1:0] BRCMP_EQ  = 3'd0;
localparam logic [MODE_W-1:0] BRCMP_NE  = 3'd1;
localparam logic [MODE_W-1:0] BRCMP_LTZ = 3'd2;
localparam logic [MODE_W-1:0] BRCMP_GEZ = 3'd3;
localparam logic [MODE_W-1:0] BRCMP_GTZ = 3'd4;
localparam logic [MODE_W-1:0] BRCMP_LEZ = 3'd5;
localparam logic [MODE_W-1:0] BRCMP_LT  = 3'd6;
localparam logic [MODE_W-1:0] BRCMP_LTU = 3'd7;
`endif

// File: rtl/branch_compare_pipe.sv
// Two-stage pipelined branch condition unit with valid/ready handshakes and flush.
// Optional hit counters are built when BRCMP_STATS_EN is defined.
module branch_compare_pipe
  import branch_compare_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_eq,
`ifdef BRCMP_STATS_EN
  output logic [31:0]       stat_evals,
  output logic [31:0]       stat_taken,
`endif
  output logic [TAG_W-1:0]  out_tag
);
  localparam int NCHUNK = WIDTH / CHUNK;

  logic [NCHUNK-1:0] eq_next, ltu_next, zero_next;
  logic [NCHUNK-1:0] s1_eq_reg, s1_ltu_reg, s1_zero_reg;
  logic              s1_sign_a_reg, s1_sign_b_reg, s1_valid_reg;
  brcmp_mode_t       s1_mode_reg;
  logic [TAG_W-1:0]  s1_tag_reg;

  logic              out_valid_reg, out_taken_reg, out_eq_reg;
  logic [TAG_W-1:0]  out_tag_reg;

  logic              s2_load, in_fire;
  logic              eq_red, zero_red, lt_signed, taken_next;
  logic [NCHUNK:0]   lt_chain;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      brcmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (in_a[gi*CHUNK +: CHUNK]),
        .b    (in_b[gi*CHUNK +: CHUNK]),
        .eq   (eq_next[gi]),
        .ltu  (ltu_next[gi]),
        .zero (zero_next[gi])
      );
    end
  endgenerate

  assign s2_load  = !out_valid_reg || out_ready;
  assign in_ready = !flush && (!s1_valid_reg || s2_load);
  assign in_fire  = in_valid && in_ready;

  // Unsigned less-than: a higher chunk decides unless it is equal, then defer downward.
  assign lt_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_lt
      assign lt_chain[gi+1] = s1_ltu_reg[gi] || (s1_eq_reg[gi] && lt_chain[gi]);
    end
  endgenerate

  assign eq_red     = &s1_eq_reg;
  assign zero_red   = &s1_zero_reg;
  assign lt_signed  = (s1_sign_a_reg != s1_sign_b_reg) ? s1_sign_a_reg : lt_chain[NCHUNK];
  assign taken_next = brcmp_taken(s1_mode_reg, eq_red, zero_red, s1_sign_a_reg,
                                  lt_signed, lt_chain[NCHUNK]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_eq_reg     <= '0;
      s1_ltu_reg    <= '0;
      s1_zero_reg   <= '0;
      s1_sign_a_reg <= 1'b0;
      s1_sign_b_reg <= 1'b0;
      s1_mode_reg   <= '0;
      s1_tag_reg    <= '0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
    end else if (in_fire) begin
      s1_valid_reg  <= 1'b1;
      s1_eq_reg     <= eq_next;
      s1_ltu_reg    <= ltu_next;
      s1_zero_reg   <= zero_next;
      s1_sign_a_reg <= in_a[WIDTH-1];
      s1_sign_b_reg <= in_b[WIDTH-1];
      s1_mode_reg   <= in_mode;
      s1_tag_reg    <= in_tag;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Result registers only load on a real entry so outputs hold while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_taken_reg <= 1'b0;
      out_eq_reg    <= 1'b0;
      out_tag_reg   <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_taken_reg <= taken_next;
        out_eq_reg    <= eq_red;
        out_tag_reg   <= s1_tag_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_taken = out_taken_reg;
  assign out_eq    = out_eq_reg;
  assign out_tag   = out_tag_reg;

`ifdef BRCMP_STATS_EN
  logic [31:0] stat_evals_reg, stat_taken_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_evals_reg <= '0;
      stat_taken_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      stat_evals_reg <= stat_evals_reg + 32'd1;
      if (out_taken_reg)
        stat_taken_reg <= stat_taken_reg + 32'd1;
    end
  end

  assign stat_evals = stat_evals_reg;
  assign stat_taken = stat_taken_reg;
`endif
endmodule

// File: tb/tb_branch_compare_pipe.sv
// Directed self-checking bench for branch_compare_pipe (default 32/8/5 build).
module tb_branch_compare_pipe;
  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, out_taken, out_eq;
  logic [4:0]  out_tag;
`ifdef BRCMP_STATS_EN
  logic [31:0] stat_evals, stat_taken;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  branch_compare_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_eq     (out_eq),
`ifdef BRCMP_STATS_EN
    .stat_evals (stat_evals),
    .stat_taken (stat_taken),
`endif
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with out_ready held high; checks 2-cycle latency and result.
  task automatic run_vec(input string name, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input logic exp_taken, input logic exp_eq);
    in_mode = m; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({name, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({name, ".lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    check({name, ".valid"}, 64'(out_valid), 64'd1);
    check({name, ".taken"}, 64'(out_taken), 64'(exp_taken));
    check({name, ".eq"},    64'(out_eq),    64'(exp_eq));
    check({name, ".tag"},   64'(out_tag),   64'(t));
  endtask

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic        eq;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;

    vecs.push_back('{"eq_same",      3'd0, 32'h1234ABCD, 32'h1234ABCD, 1'b1, 1'b1});
    vecs.push_back('{"lt_neg1_1",    3'd6, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{"ltu_neg1_1",   3'd7, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{"ltu_xchunk",   3'd7, 32'h00010000, 32'h0000FFFF, 1'b0, 1'b0});
    vecs.push_back('{"ltu_xchunk_r", 3'd7, 32'h0000FFFF, 32'h00010000, 1'b1, 1'b0});
    vecs.push_back('{"ltu_low_chk",  3'd7, 32'h00000100, 32'h00000101, 1'b1, 1'b0});
    vecs.push_back('{"gez_0",        3'd3, 32'h00000000, 32'h00000005, 1'b1, 1'b0});
    vecs.push_back('{"lez_0",        3'd5, 32'h00000000, 32'h00000005, 1'b1, 1'b0});
    vecs.push_back('{"gtz_0",        3'd4, 32'h00000000, 32'h00000005, 1'b0, 1'b0});
    vecs.push_back('{"ltz_0",        3'd2, 32'h00000000, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{"ltz_min",      3'd2, 32'h80000000, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"lez_min",      3'd5, 32'h80000000, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"gtz_min",      3'd4, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"gez_min",      3'd3, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"gtz_1",        3'd4, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"ne_same",      3'd1, 32'h00000005, 32'h00000005, 1'b0, 1'b1});
    vecs.push_back('{"ne_diff",      3'd1, 32'h00000005, 32'h00000006, 1'b1, 1'b0});
    vecs.push_back('{"lt_1_neg1",    3'd6, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"lt_min_max",   3'd6, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{"eq_diff_hi",   3'd0, 32'h0234ABCD, 32'h1234ABCD, 1'b0, 1'b0});

    #12;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.out_taken", 64'(out_taken), 64'd0);
    check("reset.out_eq",    64'(out_eq),    64'd0);
    check("reset.out_tag",   64'(out_tag),   64'd0);
    rst_n = 1'b1;
    tick();
    check("reset.in_ready", 64'(in_ready), 64'd1);

    // Directed mode vectors; first one carries tag 3.
    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, 5'(i + 3),
              vecs[i].taken, vecs[i].eq);
    tick();

    // Back-to-back A(10), B(11), C(12) with the consumer stalled.
    out_ready = 1'b0;
    in_mode = 3'd0; in_a = 32'h1; in_b = 32'h1; in_tag = 5'd10; in_valid = 1'b1;
    tick();
    in_a = 32'h2; in_b = 32'h3; in_tag = 5'd11;
    #1;
    check("b2b.B_ready", 64'(in_ready), 64'd1);
    tick();
    in_a = 32'h4; in_b = 32'h4; in_tag = 5'd12;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall.in_ready", 64'(in_ready),  64'd0);
      check("stall.valid",    64'(out_valid), 64'd1);
      check("stall.A_tag",    64'(out_tag),   64'd10);
      check("stall.A_taken",  64'(out_taken), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release.C_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("drain.B_valid", 64'(out_valid), 64'd1);
    check("drain.B_tag",   64'(out_tag),   64'd11);
    check("drain.B_taken", 64'(out_taken), 64'd0);
    tick();
    check("drain.C_valid", 64'(out_valid), 64'd1);
    check("drain.C_tag",   64'(out_tag),   64'd12);
    check("drain.C_taken", 64'(out_taken), 64'd1);
    tick();
    check("drain.empty", 64'(out_valid), 64'd0);

    // Flush with two entries in flight and a request offered in the flush cycle.
    in_mode = 3'd0; in_a = 32'h7; in_b = 32'h7; in_tag = 5'd20; in_valid = 1'b1;
    tick();
    in_tag = 5'd21;
    tick();
    in_tag = 5'd22; flush = 1'b1;
    #1;
    check("flush.in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("flush.no_stale", 64'(out_valid), 64'd0);
      tick();
    end

    // Async reset in the middle of a stall.
    out_ready = 1'b0;
    in_tag = 5'd25; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("areset.pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset.valid", 64'(out_valid), 64'd0);
    check("areset.tag",   64'(out_tag),   64'd0);
    #1 rst_n = 1'b1;
    tick();

`ifdef BRCMP_STATS_EN
    check("stats.reset_evals", 64'(stat_evals), 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) run_vec("stats_eq", 3'd0, 32'h9, 32'h9, 5'(i), 1'b1, 1'b1);
      else       run_vec("stats_ne", 3'd1, 32'h9, 32'h9, 5'(i), 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    check("stats.evals", 64'(stat_evals), 64'd10);
    check("stats.taken", 64'(stat_taken), 64'd4);
    rst_n = 1'b0;
    #1;
    check("stats.evals_rst", 64'(stat_evals), 64'd0);
    check("stats.taken_rst", 64'(stat_taken), 64'd0);
    rst_n = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
